// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with 2-of-3 majority.
// Errored frames pulse PAR_ERR/STP_ERR and leave P_DATA untouched.
module uart_rx #(
    parameter int DATA_W = 8,
    parameter int OVS    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic [DATA_W-1:0] P_DATA,
    output logic              DATA_VALID,
    output logic              PAR_ERR,
    output logic              STP_ERR,
    output logic              BUSY
);

    localparam int EW = $clog2(OVS);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [EW-1:0] E_S0   = EW'(OVS / 2 - 1);
    localparam logic [EW-1:0] E_S1   = EW'(OVS / 2);
    localparam logic [EW-1:0] E_S2   = EW'(OVS / 2 + 1);
    localparam logic [EW-1:0] E_LAST = EW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q;
    logic [1:0]        sync_q;
    logic [EW-1:0]     edge_cnt_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [2:0]        smp_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_en_q;
    logic              par_typ_q;
    logic              perr_q;

    logic rx_s;
    logic bit_end;
    logic bit_v;

    assign rx_s    = sync_q[1];
    assign bit_end = (edge_cnt_q == E_LAST);
    assign bit_v   = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2])
                   | (smp_q[1] & smp_q[2]);
    assign BUSY    = (state_q != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            perr_q     <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state_q != IDLE) begin
                edge_cnt_q <= bit_end ? '0 : edge_cnt_q + 1'b1;
                if (edge_cnt_q == E_S0) smp_q[0] <= rx_s;
                if (edge_cnt_q == E_S1) smp_q[1] <= rx_s;
                if (edge_cnt_q == E_S2) smp_q[2] <= rx_s;
            end

            unique case (state_q)
                IDLE: begin
                    // Detection cycle is edge 0 of the start bit.
                    if (!rx_s) begin
                        state_q    <= START;
                        edge_cnt_q <= EW'(1);
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        perr_q     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (bit_v) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= {bit_v, shift_q[DATA_W-1:1]};
                        if (bit_cnt_q == B_LAST) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        perr_q  <= ((^shift_q) ^ bit_v) != par_typ_q;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        if (!perr_q && bit_v) begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= shift_q;
                        end else begin
                            PAR_ERR <= perr_q;
                            STP_ERR <= !bit_v;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (DATA_W=8, OVS=8).
// Cycle N of a frame is observed at the falling edge after rising edge N-1.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx #(.DATA_W(8), .OVS(8)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .RX_IN     (rx_in),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .DATA_VALID(data_valid),
        .PAR_ERR   (par_err),
        .STP_ERR   (stp_err),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    int pc = 0;
    int p0 = 0;
    int dv_n, pe_n, se_n;
    int dv_pc, pe_pc, se_pc;
    int busy_first_pc, busy_last_pc;
    logic [7:0] dv_q[$];

    always @(posedge clk) pc++;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_n++;
            dv_pc = pc;
            dv_q.push_back(p_data);
        end
        if (par_err) begin
            pe_n++;
            pe_pc = pc;
        end
        if (stp_err) begin
            se_n++;
            se_pc = pc;
        end
        if (busy) begin
            if (busy_first_pc < 0) busy_first_pc = pc;
            busy_last_pc = pc;
        end
    end

    function automatic int cyc(input int p);
        return p - p0 + 1;
    endfunction

    task automatic clr();
        dv_n = 0; pe_n = 0; se_n = 0;
        dv_pc = 0; pe_pc = 0; se_pc = 0;
        busy_first_pc = -1; busy_last_pc = -1;
        dv_q.delete();
    endtask

    // Caller must be at a falling edge; returns at a falling edge.
    task automatic send_frame(input logic [7:0] d, input bit has_par,
                              input bit pbit, input bit stop);
        p0 = pc + 1;
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (8) @(negedge clk);
        end
        if (has_par) begin
            rx_in = pbit;
            repeat (8) @(negedge clk);
        end
        rx_in = stop;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (p_data !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_pdata: got %h want 00", p_data);
        end
        compared++;
        if ({data_valid, par_err, stp_err, busy} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 0000",
                     {data_valid, par_err, stp_err, busy});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_parity_ok();
        clr();
        par_en = 1'b1; par_typ = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        compared++;
        if (dv_n !== 1 || cyc(dv_pc) !== 90) begin
            mismatched++;
            $display("FAIL par_ok_dv: got n=%0d cyc=%0d want n=1 cyc=90",
                     dv_n, cyc(dv_pc));
        end
        compared++;
        if (p_data !== 8'hA5) begin
            mismatched++;
            $display("FAIL par_ok_data: got %h want a5", p_data);
        end
        compared++;
        if (pe_n !== 0 || se_n !== 0) begin
            mismatched++;
            $display("FAIL par_ok_err: got pe=%0d se=%0d want 0 0", pe_n, se_n);
        end
    endtask

    task automatic test_no_parity();
        clr();
        par_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        compared++;
        if (dv_n !== 1 || cyc(dv_pc) !== 82) begin
            mismatched++;
            $display("FAIL nopar_dv: got n=%0d cyc=%0d want n=1 cyc=82",
                     dv_n, cyc(dv_pc));
        end
        compared++;
        if (p_data !== 8'h3C) begin
            mismatched++;
            $display("FAIL nopar_data: got %h want 3c", p_data);
        end
        compared++;
        if (cyc(busy_first_pc) !== 3 || cyc(busy_last_pc) !== 81) begin
            mismatched++;
            $display("FAIL nopar_busy: got %0d..%0d want 3..81",
                     cyc(busy_first_pc), cyc(busy_last_pc));
        end
    endtask

    task automatic test_parity_err();
        clr();
        par_en = 1'b1; par_typ = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        compared++;
        if (pe_n !== 1 || cyc(pe_pc) !== 90) begin
            mismatched++;
            $display("FAIL parerr_pulse: got n=%0d cyc=%0d want n=1 cyc=90",
                     pe_n, cyc(pe_pc));
        end
        compared++;
        if (dv_n !== 0 || se_n !== 0) begin
            mismatched++;
            $display("FAIL parerr_other: got dv=%0d se=%0d want 0 0", dv_n, se_n);
        end
        compared++;
        if (p_data !== 8'h3C) begin
            mismatched++;
            $display("FAIL parerr_hold: got %h want 3c", p_data);
        end
        par_typ = 1'b0;
    endtask

    task automatic test_stop_err();
        clr();
        par_en = 1'b0;
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        compared++;
        if (se_n !== 1 || cyc(se_pc) !== 82) begin
            mismatched++;
            $display("FAIL stperr_pulse: got n=%0d cyc=%0d want n=1 cyc=82",
                     se_n, cyc(se_pc));
        end
        compared++;
        if (dv_n !== 0 || pe_n !== 0 || p_data !== 8'h3C) begin
            mismatched++;
            $display("FAIL stperr_other: got dv=%0d pe=%0d data=%h want 0 0 3c",
                     dv_n, pe_n, p_data);
        end
    endtask

    task automatic test_glitch();
        clr();
        p0 = pc + 1;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        compared++;
        if (dv_n !== 0 || pe_n !== 0 || se_n !== 0) begin
            mismatched++;
            $display("FAIL glitch_pulse: got dv=%0d pe=%0d se=%0d want 0 0 0",
                     dv_n, pe_n, se_n);
        end
        compared++;
        if (cyc(busy_first_pc) !== 3 || cyc(busy_last_pc) !== 9 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_busy: got %0d..%0d now=%b want 3..9 now=0",
                     cyc(busy_first_pc), cyc(busy_last_pc), busy);
        end
    endtask

    task automatic test_cfg_change();
        clr();
        par_en = 1'b1; par_typ = 1'b0;
        fork
            send_frame(8'h81, 1'b1, 1'b0, 1'b1);
            begin
                repeat (20) @(negedge clk);
                par_en = 1'b0;
                par_typ = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        compared++;
        if (dv_n !== 1 || cyc(dv_pc) !== 90 || p_data !== 8'h81) begin
            mismatched++;
            $display("FAIL cfgchg: got n=%0d cyc=%0d data=%h want 1 90 81",
                     dv_n, cyc(dv_pc), p_data);
        end
        compared++;
        if (pe_n !== 0 || se_n !== 0) begin
            mismatched++;
            $display("FAIL cfgchg_err: got pe=%0d se=%0d want 0 0", pe_n, se_n);
        end
        par_en = 1'b0; par_typ = 1'b0;
    endtask

    task automatic test_held_low();
        clr();
        par_en = 1'b0;
        p0 = pc + 1;
        rx_in = 1'b0;
        repeat (82) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        compared++;
        if (se_n !== 1 || cyc(se_pc) !== 82) begin
            mismatched++;
            $display("FAIL low_stperr: got n=%0d cyc=%0d want n=1 cyc=82",
                     se_n, cyc(se_pc));
        end
        compared++;
        if (dv_n !== 0 || pe_n !== 0 || p_data !== 8'h81) begin
            mismatched++;
            $display("FAIL low_other: got dv=%0d pe=%0d data=%h want 0 0 81",
                     dv_n, pe_n, p_data);
        end
        compared++;
        if (cyc(busy_last_pc) !== 89 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL low_restart: got last=%0d now=%b want 89 0",
                     cyc(busy_last_pc), busy);
        end
    endtask

    task automatic test_back_to_back();
        clr();
        par_en = 1'b0;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (39) @(negedge clk);
                compared++;
                if (busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_midbusy: got %b want 1", busy);
                end
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                compared++;
                if (p_data !== 8'h00 || busy !== 1'b0 ||
                    {data_valid, par_err, stp_err} !== 3'b000) begin
                    mismatched++;
                    $display("FAIL b2b_rstclr: got data=%h busy=%b flags=%b want 00 0 000",
                             p_data, busy, {data_valid, par_err, stp_err});
                end
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (30) @(negedge clk);
        compared++;
        if (dv_n !== 2) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d want 2", dv_n);
        end
        compared++;
        if (dv_q.size() != 2 || dv_q[0] !== 8'h01 || dv_q[1] !== 8'hFF) begin
            mismatched++;
            $display("FAIL b2b_data: got size=%0d want 01,ff", dv_q.size());
        end
        compared++;
        if (pe_n !== 0 || se_n !== 0 || busy !== 1'b0 || p_data !== 8'h00) begin
            mismatched++;
            $display("FAIL b2b_after: got pe=%0d se=%0d busy=%b data=%h want 0 0 0 00",
                     pe_n, se_n, busy, p_data);
        end
        clr();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        compared++;
        if (dv_n !== 1 || cyc(dv_pc) !== 82 || p_data !== 8'h5A) begin
            mismatched++;
            $display("FAIL b2b_resume: got n=%0d cyc=%0d data=%h want 1 82 5a",
                     dv_n, cyc(dv_pc), p_data);
        end
    endtask

    initial begin
        clr();
        @(negedge clk);
        test_reset();
        test_parity_ok();
        test_no_parity();
        test_parity_err();
        test_stop_err();
        test_glitch();
        test_cfg_change();
        test_held_low();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
